// File: rtl/dm_responder.sv
// Data-memory responder for the M-stage data port: combinational word read, byte-enabled writes, store trace FIFO.
// Optional range checking is enabled by defining DM_OOR_CHECK_EN.
module dm_responder #(
    parameter int unsigned ADDR_WORDS  = 4096,
    parameter int unsigned LIMIT_WORDS = 3072,
    parameter int unsigned TRC_DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  m_data_addr,
    input  logic [31:0]                  m_data_wdata,
    input  logic [3:0]                   m_data_byteen,
    input  logic [31:0]                  m_inst_addr,
    output logic [31:0]                  m_data_rdata,
    output logic                         trc_valid,
    input  logic                         trc_ready,
    output logic [31:0]                  trc_pc,
    output logic [31:0]                  trc_addr,
    output logic [31:0]                  trc_data,
    output logic [$clog2(TRC_DEPTH):0]   trc_count,
    output logic                         trc_overflow,
    output logic                         oor_err
);

    localparam int unsigned AW = $clog2(ADDR_WORDS);
    localparam int unsigned PW = $clog2(TRC_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } trc_t;

    logic [31:0]   mem_q [ADDR_WORDS];
    trc_t          fifo_q [TRC_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    trc_t          last_q, last_d;
    logic          ovf_q, ovf_d;
    logic          oor_q, oor_d;

    logic [AW-1:0] idx;
    logic          oor;
    logic [31:0]   word_cur;
    logic [31:0]   merged;
    logic          wr_en;
    logic          full;
    logic          valid;
    logic          pop;
    logic          push_ok;
    trc_t          head;
    trc_t          new_entry;
    logic          unused_ok;

    assign idx      = m_data_addr[AW+1:2];
    assign word_cur = mem_q[idx];

`ifdef DM_OOR_CHECK_EN
    assign oor = (32'(idx) >= LIMIT_WORDS);
`else
    assign oor = 1'b0;
`endif

    assign unused_ok = ^{m_data_addr[1:0], (LIMIT_WORDS != 0)};

    assign m_data_rdata = oor ? '0 : word_cur;

    assign merged = {
        m_data_byteen[3] ? m_data_wdata[31:24] : word_cur[31:24],
        m_data_byteen[2] ? m_data_wdata[23:16] : word_cur[23:16],
        m_data_byteen[1] ? m_data_wdata[15:8]  : word_cur[15:8],
        m_data_byteen[0] ? m_data_wdata[7:0]   : word_cur[7:0]
    };

    assign wr_en = (m_data_byteen != 4'b0000) && !oor;

    assign full    = (count_q == (PW+1)'(TRC_DEPTH));
    assign valid   = (count_q != '0);
    assign pop     = valid && trc_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok = wr_en && (!full || pop);

    assign head      = fifo_q[rd_ptr_q];
    assign new_entry = '{pc: m_inst_addr, addr: {m_data_addr[31:2], 2'b00}, data: merged};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        ovf_d    = ovf_q;
        oor_d    = oor_q | oor;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            last_d   = head;
        end
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (wr_en && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q <= '{default: '0};
        end else if (wr_en) begin
            mem_q[idx] <= merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_q <= '{default: '0};
        end else if (push_ok) begin
            fifo_q[wr_ptr_q] <= new_entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
            ovf_q    <= 1'b0;
            oor_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
            oor_q    <= oor_d;
        end
    end

    // When empty, the last popped entry stays on the trace outputs.
    assign trc_valid    = valid;
    assign trc_pc       = valid ? head.pc   : last_q.pc;
    assign trc_addr     = valid ? head.addr : last_q.addr;
    assign trc_data     = valid ? head.data : last_q.data;
    assign trc_count    = count_q;
    assign trc_overflow = ovf_q;
    assign oor_err      = oor_q;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: expected trace entries are queued at issue and popped by a monitor.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] m_data_addr = '0;
    logic [31:0] m_data_wdata = '0;
    logic [3:0]  m_data_byteen = '0;
    logic [31:0] m_inst_addr = '0;
    logic [31:0] m_data_rdata;
    logic        trc_valid;
    logic        trc_ready = 1'b0;
    logic [31:0] trc_pc;
    logic [31:0] trc_addr;
    logic [31:0] trc_data;
    logic [3:0]  trc_count;
    logic        trc_overflow;
    logic        oor_err;

    dm_responder #(
        .ADDR_WORDS (4096),
        .LIMIT_WORDS(3072),
        .TRC_DEPTH  (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .m_data_addr  (m_data_addr),
        .m_data_wdata (m_data_wdata),
        .m_data_byteen(m_data_byteen),
        .m_inst_addr  (m_inst_addr),
        .m_data_rdata (m_data_rdata),
        .trc_valid    (trc_valid),
        .trc_ready    (trc_ready),
        .trc_pc       (trc_pc),
        .trc_addr     (trc_addr),
        .trc_data     (trc_data),
        .trc_count    (trc_count),
        .trc_overflow (trc_overflow),
        .oor_err      (oor_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } trc_e_t;

    chk_t   dq[$];
    trc_e_t sq[$];
    int     n_vec = 0;
    int     n_fail = 0;
    chk_t   c;
    trc_e_t e;

    // Monitor: owns all counters; resolves queued direct checks and trace handshakes.
    always @(negedge clk) begin
        while (dq.size() > 0) begin
            c = dq.pop_front();
            n_vec++;
            if (c.act !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", c.nm, c.act, c.exp);
            end
        end
        if (reset && trc_valid && trc_ready) begin
            if (sq.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL trace_unexpected: got pc %h addr %h data %h expected no entry",
                         trc_pc, trc_addr, trc_data);
            end else begin
                e = sq.pop_front();
                n_vec++;
                if (trc_pc !== e.pc) begin
                    n_fail++;
                    $display("FAIL trace_pc: got %h expected %h", trc_pc, e.pc);
                end
                n_vec++;
                if (trc_addr !== e.addr) begin
                    n_fail++;
                    $display("FAIL trace_addr: got %h expected %h", trc_addr, e.addr);
                end
                n_vec++;
                if (trc_data !== e.data) begin
                    n_fail++;
                    $display("FAIL trace_data: got %h expected %h", trc_data, e.data);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        dq.push_back('{nm: nm, act: act, exp: exp});
    endtask

    task automatic expect_trace(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] data);
        sq.push_back('{pc: pc, addr: addr, data: data});
    endtask

    // Inputs take effect at the following rising edge; checks after this call see pre-edge state.
    task automatic drv(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                       input logic [31:0] pc, input logic rdy);
        @(posedge clk);
        #1;
        m_data_addr   = a;
        m_data_wdata  = wd;
        m_data_byteen = be;
        m_inst_addr   = pc;
        trc_ready     = rdy;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("reset_valid", {31'b0, trc_valid}, 32'h0);
        chk("reset_count", {28'b0, trc_count}, 32'h0);
        chk("reset_ovf", {31'b0, trc_overflow}, 32'h0);
        chk("reset_oor", {31'b0, oor_err}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        drv(32'h10, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("rd_after_reset", m_data_rdata, 32'h0);
        chk("reset_pc", trc_pc, 32'h0);
        chk("reset_addr", trc_addr, 32'h0);
        chk("reset_data", trc_data, 32'h0);

        drv(32'h20, 32'hDEADBEEF, 4'hF, 32'h3000, 1'b0);
        chk("sw_prewrite_rd", m_data_rdata, 32'h0);
        expect_trace(32'h3000, 32'h20, 32'hDEADBEEF);

        drv(32'h20, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("sw_rd", m_data_rdata, 32'hDEADBEEF);
        chk("sw_valid", {31'b0, trc_valid}, 32'h1);
        chk("sw_count", {28'b0, trc_count}, 32'h1);
        chk("sw_head_pc", trc_pc, 32'h3000);
        chk("sw_head_addr", trc_addr, 32'h20);
        chk("sw_head_data", trc_data, 32'hDEADBEEF);

        drv(32'h21, 32'h0000_5500, 4'b0010, 32'h3004, 1'b0);
        chk("sb_prewrite_rd", m_data_rdata, 32'hDEADBEEF);
        expect_trace(32'h3004, 32'h20, 32'hDEAD55EF);

        drv(32'h20, 32'h0, 4'h0, 32'h0, 1'b1);
        chk("sb_rd", m_data_rdata, 32'hDEAD55EF);
        chk("sb_count", {28'b0, trc_count}, 32'h2);
        drv(32'h20, 32'h0, 4'h0, 32'h0, 1'b1);
        chk("drain1_count", {28'b0, trc_count}, 32'h1);
        drv(32'h20, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("drained_valid", {31'b0, trc_valid}, 32'h0);
        chk("drained_count", {28'b0, trc_count}, 32'h0);
        chk("hold_last_data", trc_data, 32'hDEAD55EF);
        chk("hold_last_pc", trc_pc, 32'h3004);

        for (int k = 0; k < 8; k++) begin
            drv(32'h100 + 32'(4 * k), 32'h1000_0000 + 32'(k), 4'hF, 32'h4000 + 32'(4 * k), 1'b0);
            expect_trace(32'h4000 + 32'(4 * k), 32'h100 + 32'(4 * k), 32'h1000_0000 + 32'(k));
        end
        drv(32'h100, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("full_count", {28'b0, trc_count}, 32'h8);
        chk("full_ovf", {31'b0, trc_overflow}, 32'h0);
        chk("full_valid", {31'b0, trc_valid}, 32'h1);

        drv(32'h120, 32'h1000_0008, 4'hF, 32'h4020, 1'b1);
        expect_trace(32'h4020, 32'h120, 32'h1000_0008);
        drv(32'h124, 32'h1000_0009, 4'hF, 32'h4024, 1'b0);
        chk("full_pushpop_count", {28'b0, trc_count}, 32'h8);
        chk("full_pushpop_ovf", {31'b0, trc_overflow}, 32'h0);
        drv(32'h100, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("drop_count", {28'b0, trc_count}, 32'h8);
        chk("drop_ovf", {31'b0, trc_overflow}, 32'h1);

        for (int k = 0; k < 10; k++) begin
            drv(32'h100 + 32'(4 * k), 32'h0, 4'h0, 32'h0, 1'b0);
            chk("mem_readback", m_data_rdata, 32'h1000_0000 + 32'(k));
        end

        repeat (8) drv(32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
        drv(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("drain_all_valid", {31'b0, trc_valid}, 32'h0);
        chk("drain_all_count", {28'b0, trc_count}, 32'h0);
        chk("drain_hold_data", trc_data, 32'h1000_0008);
        chk("drain_hold_addr", trc_addr, 32'h120);
        chk("ovf_sticky", {31'b0, trc_overflow}, 32'h1);

        drv(32'h4020, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("index_wrap_rd", m_data_rdata, 32'hDEAD55EF);

        drv(32'h3000, 32'hCAFE_F00D, 4'hF, 32'h6000, 1'b0);
        chk("oor_prewrite_rd", m_data_rdata, 32'h0);
`ifndef DM_OOR_CHECK_EN
        expect_trace(32'h6000, 32'h3000, 32'hCAFE_F00D);
`endif
        drv(32'h3000, 32'h0, 4'h0, 32'h0, 1'b0);
`ifdef DM_OOR_CHECK_EN
        chk("oor_rd", m_data_rdata, 32'h0);
        chk("oor_count", {28'b0, trc_count}, 32'h0);
        chk("oor_flag", {31'b0, oor_err}, 32'h1);
`else
        chk("hi_idx_rd", m_data_rdata, 32'hCAFE_F00D);
        chk("hi_idx_count", {28'b0, trc_count}, 32'h1);
        chk("hi_idx_oor", {31'b0, oor_err}, 32'h0);
`endif
        drv(32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
        drv(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("post_oor_count", {28'b0, trc_count}, 32'h0);

        // Pending entry is deliberately not queued: reset must discard it.
        drv(32'h40, 32'h1234_5678, 4'hF, 32'h7000, 1'b0);
        drv(32'h40, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("pre_reset_rd", m_data_rdata, 32'h1234_5678);
        chk("pre_reset_count", {28'b0, trc_count}, 32'h1);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midreset_count", {28'b0, trc_count}, 32'h0);
        chk("midreset_valid", {31'b0, trc_valid}, 32'h0);
        chk("midreset_ovf", {31'b0, trc_overflow}, 32'h0);
        chk("midreset_oor", {31'b0, oor_err}, 32'h0);
        chk("midreset_rd40", m_data_rdata, 32'h0);
        m_data_addr = 32'h20;
        #1;
        chk("midreset_rd20", m_data_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        drv(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
        chk("scoreboard_empty", 32'(sq.size()), 32'h0);

        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
